// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: imem req/gnt issue, in-order response tagging, flush discard, output FIFO
// Optional build macro: FETCH_MISALIGN_CHECK_EN adds inst_misalign_o.
module fetch_unit #(
   parameter int DEPTH           = 4,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_i,
   input  logic        pc_valid_i,
   output logic        pc_ready_o,
   input  logic        flush_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic        inst_valid_o,
   input  logic        inst_ready_i,
   output logic [31:0] inst_o,
`ifdef FETCH_MISALIGN_CHECK_EN
   output logic        inst_misalign_o,
`endif
   output logic [31:0] inst_pc_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   localparam logic [CW-1:0] MAX_C   = CW'(MAX_OUTSTANDING);
   localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);
   localparam logic [TW-1:0] TLAST_C = TW'(MAX_OUTSTANDING - 1);

   localparam logic [0:0] ST_FETCH   = 1'b0;
   localparam logic [0:0] ST_DISCARD = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [CW-1:0] out_q, out_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] disc_q, disc_d;
   logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [TW-1:0] twr_q, twr_d, trd_q, trd_d;

   logic [31:0] tag_q      [MAX_OUTSTANDING];
   logic [31:0] mem_inst_q [DEPTH];
   logic [31:0] mem_pc_q   [DEPTH];
   logic [31:0] last_inst_q, last_pc_q;

   logic          can_issue, grant, rsp, discard_rsp, push, pop;
   logic [CW-1:0] out_after;
   logic [31:0]   tag_head;

   function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
      return (p == TLAST_C) ? '0 : p + 1'b1;
   endfunction

   // Credit counts in-flight requests against FIFO space so every response has a slot.
   assign can_issue   = (out_q < MAX_C) && (({1'b0, out_q} + {1'b0, cnt_q}) < DEPTH_C);
   assign imem_req_o  = rst & pc_valid_i & can_issue & (state_q == ST_FETCH) & ~flush_i;
   assign imem_addr_o = rst ? {pc_i[31:2], 2'b00} : 32'h0;
   assign pc_ready_o  = imem_req_o & imem_gnt_i;
   assign grant       = pc_ready_o;

   assign rsp         = rst & imem_rvalid_i;
   assign discard_rsp = rsp & (disc_q != '0);
   assign push        = rsp & ~discard_rsp & ~flush_i;
   assign pop         = (cnt_q != '0) & inst_ready_i & ~flush_i;
   assign out_after   = out_q + CW'(grant) - CW'(rsp);
   assign tag_head    = tag_q[trd_q];

   always_comb begin
      state_d = state_q;
      disc_d  = disc_q;
      out_d   = out_after;
      cnt_d   = cnt_q + CW'(push) - CW'(pop);
      wr_d    = wr_q + PW'(push);
      rd_d    = rd_q + PW'(pop);
      twr_d   = grant ? tag_inc(twr_q) : twr_q;
      trd_d   = push ? tag_inc(trd_q) : trd_q;
      if (flush_i) begin
         // The response landing in the flush cycle is already counted out of out_after and dropped.
         disc_d  = out_after;
         state_d = (out_after != '0) ? ST_DISCARD : ST_FETCH;
         cnt_d   = '0;
         wr_d    = '0;
         rd_d    = '0;
         twr_d   = '0;
         trd_d   = '0;
      end else if (discard_rsp) begin
         disc_d = disc_q - 1'b1;
         if (disc_q == CW'(1)) state_d = ST_FETCH;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_FETCH;
         out_q       <= '0;
         cnt_q       <= '0;
         disc_q      <= '0;
         wr_q        <= '0;
         rd_q        <= '0;
         twr_q       <= '0;
         trd_q       <= '0;
         last_inst_q <= '0;
         last_pc_q   <= '0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         cnt_q   <= cnt_d;
         disc_q  <= disc_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         twr_q   <= twr_d;
         trd_q   <= trd_d;
         if (inst_valid_o) begin
            last_inst_q <= mem_inst_q[rd_q];
            last_pc_q   <= mem_pc_q[rd_q];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (grant) tag_q[twr_q] <= pc_i;
      if (push) begin
         mem_inst_q[wr_q] <= imem_rdata_i;
         mem_pc_q[wr_q]   <= tag_head;
      end
   end

   // Empty FIFO shows the last head entry rather than stale storage.
   assign inst_valid_o = (cnt_q != '0);
   assign inst_o       = inst_valid_o ? mem_inst_q[rd_q] : last_inst_q;
   assign inst_pc_o    = inst_valid_o ? mem_pc_q[rd_q]   : last_pc_q;

`ifdef FETCH_MISALIGN_CHECK_EN
   logic mem_mis_q [DEPTH];
   logic last_mis_q;

   always_ff @(posedge clk) begin
      if (push) mem_mis_q[wr_q] <= (tag_head[1:0] != 2'b00);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_mis_q <= 1'b0;
      end else if (inst_valid_o) begin
         last_mis_q <= mem_mis_q[rd_q];
      end
   end

   assign inst_misalign_o = inst_valid_o ? mem_mis_q[rd_q] : last_mis_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed vector table plus reset/backpressure/misalign sequences for fetch_unit
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_i;
   logic        pc_valid_i, pc_ready_o, flush_i;
   logic        imem_req_o, imem_gnt_i, imem_rvalid_i;
   logic [31:0] imem_addr_o, imem_rdata_i;
   logic        inst_valid_o, inst_ready_i;
   logic [31:0] inst_o, inst_pc_o;
`ifdef FETCH_MISALIGN_CHECK_EN
   logic        inst_misalign_o;
`endif

   int n_vec  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   fetch_unit #(.DEPTH(4), .MAX_OUTSTANDING(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .pc_i          (pc_i),
      .pc_valid_i    (pc_valid_i),
      .pc_ready_o    (pc_ready_o),
      .flush_i       (flush_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .inst_valid_o  (inst_valid_o),
      .inst_ready_i  (inst_ready_i),
      .inst_o        (inst_o),
`ifdef FETCH_MISALIGN_CHECK_EN
      .inst_misalign_o (inst_misalign_o),
`endif
      .inst_pc_o     (inst_pc_o)
   );

   typedef struct packed {
      logic        pv;
      logic [31:0] pc;
      logic        gnt;
      logic        rv;
      logic [31:0] rdata;
      logic        rdy;
      logic        fl;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_prdy;
      logic        e_iv;
      logic [31:0] e_inst;
      logic [31:0] e_ipc;
   } vec_t;

   vec_t vecs [12];

   function automatic vec_t mk(input logic pv, input logic [31:0] pc, input logic gnt, input logic rv,
                               input logic [31:0] rdata, input logic rdy, input logic fl,
                               input logic e_req, input logic [31:0] e_addr, input logic e_prdy,
                               input logic e_iv, input logic [31:0] e_inst, input logic [31:0] e_ipc);
      vec_t v;
      v = '{pv, pc, gnt, rv, rdata, rdy, fl, e_req, e_addr, e_prdy, e_iv, e_inst, e_ipc};
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic pv, input logic [31:0] pc, input logic gnt, input logic rv,
                        input logic [31:0] rdata, input logic rdy, input logic fl);
      pc_valid_i    = pv;
      pc_i          = pc;
      imem_gnt_i    = gnt;
      imem_rvalid_i = rv;
      imem_rdata_i  = rdata;
      inst_ready_i  = rdy;
      flush_i       = fl;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   logic        g, resp_pend, last_req, last_prdy;
   logic [31:0] resp_data, next_pc, exp_pc;
   int          grants, got;

   initial begin
      rst = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

      //                pv  pc           gnt  rv   rdata          rdy  fl    req  addr        prdy iv   inst           ipc
      vecs[0]  = mk(1'b1, 32'h0000_0000, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 32'h0,         32'h0);
      vecs[1]  = mk(1'b1, 32'h0000_0004, 1'b1, 1'b1, 32'hC000_0000, 1'b1, 1'b0, 1'b1, 32'h0000_0004, 1'b1, 1'b0, 32'h0,         32'h0);
      vecs[2]  = mk(1'b1, 32'h0000_0008, 1'b1, 1'b1, 32'hC000_0004, 1'b1, 1'b0, 1'b1, 32'h0000_0008, 1'b1, 1'b1, 32'hC000_0000, 32'h0);
      vecs[3]  = mk(1'b1, 32'h0000_000C, 1'b1, 1'b1, 32'hC000_0008, 1'b1, 1'b0, 1'b1, 32'h0000_000C, 1'b1, 1'b1, 32'hC000_0004, 32'h4);
      vecs[4]  = mk(1'b1, 32'h0000_0010, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h0000_0010, 1'b1, 1'b1, 32'hC000_0008, 32'h8);
      vecs[5]  = mk(1'b1, 32'h0000_0014, 1'b1, 1'b1, 32'hC000_000C, 1'b1, 1'b1, 1'b0, 32'h0000_0014, 1'b0, 1'b0, 32'hC000_0008, 32'h8);
      vecs[6]  = mk(1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 32'hC000_0008, 32'h8);
      vecs[7]  = mk(1'b1, 32'h0000_0100, 1'b1, 1'b1, 32'hC000_0010, 1'b1, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 32'hC000_0008, 32'h8);
      vecs[8]  = mk(1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'hC000_0008, 32'h8);
      vecs[9]  = mk(1'b0, 32'h0000_0107, 1'b1, 1'b1, 32'hD000_0100, 1'b1, 1'b0, 1'b0, 32'h0000_0104, 1'b0, 1'b0, 32'hC000_0008, 32'h8);
      vecs[10] = mk(1'b0, 32'h0000_0108, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0000_0108, 1'b0, 1'b1, 32'hD000_0100, 32'h100);
      vecs[11] = mk(1'b0, 32'h0000_0108, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0000_0108, 1'b0, 1'b0, 32'hD000_0100, 32'h100);

      @(negedge clk);
      pc_valid_i = 1'b1;
      #1;
      check("reset.req", {31'b0, imem_req_o}, 32'h0);
      check("reset.iv", {31'b0, inst_valid_o}, 32'h0);
      check("reset.inst", inst_o, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      pc_valid_i = 1'b0;

      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         drive(vecs[i].pv, vecs[i].pc, vecs[i].gnt, vecs[i].rv, vecs[i].rdata, vecs[i].rdy, vecs[i].fl);
         #1;
         check($sformatf("v%0d.req", i),  {31'b0, imem_req_o},   {31'b0, vecs[i].e_req});
         check($sformatf("v%0d.addr", i), imem_addr_o,           vecs[i].e_addr);
         check($sformatf("v%0d.prdy", i), {31'b0, pc_ready_o},   {31'b0, vecs[i].e_prdy});
         check($sformatf("v%0d.iv", i),   {31'b0, inst_valid_o}, {31'b0, vecs[i].e_iv});
         check($sformatf("v%0d.inst", i), inst_o,                vecs[i].e_inst);
         check($sformatf("v%0d.ipc", i),  inst_pc_o,             vecs[i].e_ipc);
      end

      // Backpressure: decode stalled, imem answers one cycle after each grant.
      do_reset();
      next_pc = 32'h0; resp_pend = 1'b0; resp_data = 32'h0; grants = 0;
      last_req = 1'b1; last_prdy = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         drive(1'b1, next_pc, 1'b1, resp_pend, resp_data, 1'b0, 1'b0);
         #1;
         g = imem_req_o & imem_gnt_i;
         last_req = imem_req_o;
         last_prdy = pc_ready_o;
         if (g) grants++;
         resp_data = 32'hC000_0000 | imem_addr_o;
         @(posedge clk);
         if (g) next_pc = next_pc + 32'h4;
         resp_pend = g;
      end
      check("bp.grants", grants, 4);
      check("bp.req_stalled", {31'b0, last_req}, 32'h0);
      check("bp.prdy_stalled", {31'b0, last_prdy}, 32'h0);

      exp_pc = 32'h0; got = 0;
      for (int c = 0; c < 40 && got < 8; c++) begin
         @(negedge clk);
         drive(next_pc < 32'h20, next_pc, 1'b1, resp_pend, resp_data, 1'b1, 1'b0);
         #1;
         g = imem_req_o & imem_gnt_i;
         resp_data = 32'hC000_0000 | imem_addr_o;
         if (inst_valid_o) begin
            check($sformatf("bp.pc%0d", got), inst_pc_o, exp_pc);
            check($sformatf("bp.inst%0d", got), inst_o, 32'hC000_0000 | exp_pc);
            exp_pc = exp_pc + 32'h4;
            got++;
         end
         @(posedge clk);
         if (g) next_pc = next_pc + 32'h4;
         resp_pend = g;
      end
      check("bp.count", got, 8);
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      @(negedge clk);
      #1;
      check("bp.no_dup", {31'b0, inst_valid_o}, 32'h0);

      // Reset mid-stream with 2 outstanding and 2 queued.
      do_reset();
      @(negedge clk); drive(1'b1, 32'h40, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0);
      @(negedge clk); drive(1'b1, 32'h44, 1'b1, 1'b1, 32'hC000_0040, 1'b0, 1'b0);
      @(negedge clk); drive(1'b1, 32'h48, 1'b1, 1'b1, 32'hC000_0044, 1'b0, 1'b0);
      @(negedge clk); drive(1'b1, 32'h4C, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0);
      #1;
      check("rs.pre_req", {31'b0, imem_req_o}, 32'h1);
      @(negedge clk);
      rst = 1'b0;
      drive(1'b1, 32'h300, 1'b1, 1'b1, 32'hC000_0048, 1'b1, 1'b0);
      #1;
      check("rs.req", {31'b0, imem_req_o}, 32'h0);
      check("rs.addr", imem_addr_o, 32'h0);
      check("rs.prdy", {31'b0, pc_ready_o}, 32'h0);
      check("rs.iv", {31'b0, inst_valid_o}, 32'h0);
      check("rs.inst", inst_o, 32'h0);
      check("rs.ipc", inst_pc_o, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      drive(1'b1, 32'h200, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      #1;
      check("rs.first_req", {31'b0, imem_req_o}, 32'h1);
      check("rs.first_addr", imem_addr_o, 32'h200);
      @(negedge clk);
      drive(1'b0, 32'h204, 1'b0, 1'b1, 32'hE000_0200, 1'b1, 1'b0);
      #1;
      check("rs.latency_iv", {31'b0, inst_valid_o}, 32'h0);
      @(negedge clk);
      drive(1'b0, 32'h204, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      #1;
      check("rs.iv_after", {31'b0, inst_valid_o}, 32'h1);
      check("rs.ipc_after", inst_pc_o, 32'h200);
      check("rs.inst_after", inst_o, 32'hE000_0200);

`ifdef FETCH_MISALIGN_CHECK_EN
      do_reset();
      @(negedge clk);
      drive(1'b1, 32'h6, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      #1;
      check("mis.addr", imem_addr_o, 32'h4);
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hF000_0004, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      #1;
      check("mis.ipc", inst_pc_o, 32'h6);
      check("mis.flag", {31'b0, inst_misalign_o}, 32'h1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
